// File: rtl/dcmi_capture.sv
// dcmi_capture: DCMI pixel-capture engine for OV7725-class parallel cameras.
// It oversamples the camera pins in the clk domain, so clk must run at least
// 3x pclk. Active pixels are packed PACK per word and queued in a small FIFO
// that drives a valid/ready stream. Snapshot and continuous modes are supported.
//
// Optional feature macro: DCMI_CROP_EN
//   defined   : the crop_* window selects the pixels that are captured
//   undefined : crop_* are ignored, every href-active pixel is captured and
//               out_eol marks the last word before each href fall
//
// Ports:
//   clk, rstn                  system clock, async active-low reset
//   cam_pclk/vsync/href/data   camera pins (asynchronous, sampled)
//   enable, snapshot           capture enable, single-frame mode
//   crop_x0/y0/w/h             crop window (w multiple of PACK)
//   out_data/sof/eol/valid     packed word stream, first pixel in LSBs
//   out_ready                  downstream accept
//   frame_done                 one-cycle pulse at the end of a captured frame
//   busy                       capture engine is not idle
//   overflow, clr_overflow     sticky FIFO-drop flag and its clear
//   frame_cnt                  completed-frame count, wraps
`timescale 1ns/1ps
module dcmi_capture #(
    parameter int unsigned PIX_W      = 10,
    parameter int unsigned PACK       = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cam_pclk,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [PIX_W-1:0]      cam_data,
    input  logic                  enable,
    input  logic                  snapshot,
    input  logic [CNT_W-1:0]      crop_x0,
    input  logic [CNT_W-1:0]      crop_y0,
    input  logic [CNT_W-1:0]      crop_w,
    input  logic [CNT_W-1:0]      crop_h,
    output logic [PIX_W*PACK-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [15:0]           frame_cnt
);

    localparam int unsigned WORD_W = PIX_W * PACK;
    localparam int unsigned SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned XW     = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [WORD_W-1:0] data;
    } word_t;

    // Two-flop synchronizers; the extra *_p_q stage is for edge detection
    logic             pclk_m_q, pclk_s_q, pclk_p_q;
    logic             vs_m_q, vs_s_q, vs_p_q;
    logic             href_m_q, href_s_q, href_p_q;
    logic [PIX_W-1:0] data_m_q, data_s_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pclk_m_q <= 1'b0; pclk_s_q <= 1'b0; pclk_p_q <= 1'b0;
            vs_m_q   <= 1'b0; vs_s_q   <= 1'b0; vs_p_q   <= 1'b0;
            href_m_q <= 1'b0; href_s_q <= 1'b0; href_p_q <= 1'b0;
            data_m_q <= '0;   data_s_q <= '0;
        end else begin
            pclk_m_q <= cam_pclk;  pclk_s_q <= pclk_m_q; pclk_p_q <= pclk_s_q;
            vs_m_q   <= cam_vsync; vs_s_q   <= vs_m_q;   vs_p_q   <= vs_s_q;
            href_m_q <= cam_href;  href_s_q <= href_m_q; href_p_q <= href_s_q;
            data_m_q <= cam_data;  data_s_q <= data_m_q;
        end
    end

    logic sample_c, vs_fall_c, vs_rise_c, href_fall_c;
    assign sample_c    = pclk_s_q & ~pclk_p_q;
    assign vs_fall_c   = ~vs_s_q & vs_p_q;
    assign vs_rise_c   = vs_s_q & ~vs_p_q;
    assign href_fall_c = ~href_s_q & href_p_q;

    // Capture state machine
    state_e state_q, state_d;
    logic   start_c, frame_end_c;
    logic   snap_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_c     = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            IDLE:    if (enable) state_d = WAIT_VS;
            WAIT_VS: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_fall_c) begin
                    state_d = ACTIVE;
                    start_c = 1'b1;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_rise_c) begin
                    frame_end_c = 1'b1;
                    state_d     = snap_q ? DONE : WAIT_VS;
                end
            end
            DONE:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic active_c;
    assign active_c = (state_q == ACTIVE);

    // Position counters and pixel acceptance
    logic [CNT_W-1:0] x_q, y_q;
    logic             in_win_c;

`ifdef DCMI_CROP_EN
    logic [CNT_W-1:0] x0_q, y0_q, w_q, h_q;
    logic [XW-1:0]    x_ext_c, y_ext_c, x_end_c, y_end_c;
    logic             last_x_c;

    assign x_ext_c  = {1'b0, x_q};
    assign y_ext_c  = {1'b0, y_q};
    assign x_end_c  = {1'b0, x0_q} + {1'b0, w_q};
    assign y_end_c  = {1'b0, y0_q} + {1'b0, h_q};
    assign in_win_c = (x_ext_c >= {1'b0, x0_q}) && (x_ext_c < x_end_c) &&
                      (y_ext_c >= {1'b0, y0_q}) && (y_ext_c < y_end_c);
    assign last_x_c = (x_ext_c + XW'(1)) == x_end_c;
`else
    logic unused_crop;
    assign unused_crop = ^{crop_x0, crop_y0, crop_w, crop_h};
    assign in_win_c    = 1'b1;
`endif

    logic accept_c, word_full_c;
    assign accept_c    = active_c && sample_c && href_s_q && in_win_c;

    // Packer: incoming pixel drops into its slot of the partially filled word
    logic [SLOT_W-1:0] slot_q;
    logic [WORD_W-1:0] pack_q, word_c;
    assign word_full_c = accept_c && (slot_q == SLOT_W'(PACK - 1));

    always_comb begin
        word_c = pack_q;
        for (int i = 0; i < int'(PACK); i++) begin
            if (slot_q == SLOT_W'(i)) word_c[i*PIX_W +: PIX_W] = data_s_q;
        end
    end

    logic  sof_pend_q;
    logic  stg_vld_q;
    word_t stg_q;
`ifndef DCMI_CROP_EN
    // Without a crop width the last word of a line is only known at href fall,
    // so each completed word is held until the next word or the line end
    logic              hold_q, hold_sof_q;
    logic [WORD_W-1:0] hold_data_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q        <= '0;
            y_q        <= '0;
            snap_q     <= 1'b0;
            slot_q     <= '0;
            pack_q     <= '0;
            sof_pend_q <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_q      <= '0;
`ifdef DCMI_CROP_EN
            x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0;
`else
            hold_q      <= 1'b0;
            hold_sof_q  <= 1'b0;
            hold_data_q <= '0;
`endif
        end else begin
            stg_vld_q <= 1'b0;
            if (start_c) begin
                x_q        <= '0;
                y_q        <= '0;
                snap_q     <= snapshot;
                slot_q     <= '0;
                sof_pend_q <= 1'b1;
`ifdef DCMI_CROP_EN
                x0_q <= crop_x0; y0_q <= crop_y0; w_q <= crop_w; h_q <= crop_h;
`else
                hold_q <= 1'b0;
`endif
            end else if (active_c) begin
                if (href_fall_c) begin
                    // line end: restart x, step y, drop any partial word
                    x_q    <= '0;
                    slot_q <= '0;
                    if (y_q != '1) y_q <= y_q + CNT_W'(1);
`ifndef DCMI_CROP_EN
                    if (hold_q) begin
                        stg_vld_q <= 1'b1;
                        stg_q     <= '{sof: hold_sof_q, eol: 1'b1, data: hold_data_q};
                        hold_q    <= 1'b0;
                    end
`endif
                end else if (sample_c && href_s_q) begin
                    x_q <= x_q + CNT_W'(1);
                end

                if (accept_c) begin
                    pack_q <= word_c;
                    slot_q <= word_full_c ? '0 : slot_q + SLOT_W'(1);
                end

                if (word_full_c) begin
                    sof_pend_q <= 1'b0;
`ifdef DCMI_CROP_EN
                    stg_vld_q <= 1'b1;
                    stg_q     <= '{sof: sof_pend_q, eol: last_x_c, data: word_c};
`else
                    if (hold_q) begin
                        stg_vld_q <= 1'b1;
                        stg_q     <= '{sof: hold_sof_q, eol: 1'b0, data: hold_data_q};
                    end
                    hold_q      <= 1'b1;
                    hold_sof_q  <= sof_pend_q;
                    hold_data_q <= word_c;
`endif
                end
            end else begin
`ifndef DCMI_CROP_EN
                hold_q <= 1'b0;
`endif
            end
        end
    end

    // Output FIFO; a full FIFO still accepts a write in a cycle that reads
    word_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             valid_q, full_c, rd_c, wr_c, drop_c;

    assign full_c = (lvl_q == LVL_W'(FIFO_DEPTH));
    assign rd_c   = valid_q && out_ready;
    assign wr_c   = stg_vld_q && (!full_c || rd_c);
    assign drop_c = stg_vld_q && full_c && !rd_c;

    always_comb begin
        lvl_d = lvl_q;
        if (wr_c && !rd_c)      lvl_d = lvl_q + LVL_W'(1);
        else if (!wr_c && rd_c) lvl_d = lvl_q - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wr_c) begin
                mem_q[wr_ptr_q] <= stg_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            lvl_q   <= lvl_d;
            valid_q <= (lvl_d != '0);
        end
    end

    // Status outputs
    logic        frame_done_q, busy_q, overflow_q;
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= frame_end_c;
            busy_q       <= (state_d != IDLE);
            if (frame_end_c)  frame_cnt_q <= frame_cnt_q + 16'd1;
            // a clear wins over a drop in the same cycle
            if (clr_overflow) overflow_q <= 1'b0;
            else if (drop_c)  overflow_q <= 1'b1;
        end
    end

    assign out_data   = mem_q[rd_ptr_q].data;
    assign out_sof    = mem_q[rd_ptr_q].sof;
    assign out_eol    = mem_q[rd_ptr_q].eol;
    assign out_valid  = valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/dcmi_capture.md
Name: dcmi_capture

Overview:
Parametrised DCMI pixel-capture engine for OV7725-class parallel cameras. It runs in the system clock domain and oversamples the camera pclk/vsync/href/data lines; clk must be at least 3x pclk. It crops the active window, packs PACK pixels per output word and buffers the words in a small FIFO with a valid/ready stream. Single-frame (snapshot) and continuous modes are supported. The block sits between the camera pins and the downstream frame-buffer writer. SCCB configuration is out of scope.

Parameters:
PIX_W, 10, camera data bus width in bits (8 or 10).
PACK, 2, pixels per output word; power of 2, 1..4.
FIFO_DEPTH, 8, output FIFO depth in words; power of 2, at least 2.
CNT_W, 12, width of the x/y counters and crop fields.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
cam_pclk  in  1  camera pixel clock (asynchronous, sampled)
cam_vsync  in  1  camera vsync, high during vertical blanking
cam_href  in  1  camera href, high during active line
cam_data  in  PIX_W  camera pixel data
enable  in  1  capture enable
snapshot  in  1  1 = stop after one frame, 0 = continuous
crop_x0  in  CNT_W  first captured column
crop_y0  in  CNT_W  first captured line
crop_w  in  CNT_W  captured width in pixels; multiple of PACK, nonzero
crop_h  in  CNT_W  captured height in lines, nonzero
out_data  out  PIX_W*PACK  packed pixels; first pixel in LSBs
out_sof  out  1  word is first of frame
out_eol  out  1  word is last of a cropped line
out_valid  out  1  FIFO not empty
out_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse when a frame completes
busy  out  1  state is not IDLE
overflow  out  1  sticky; word dropped because the FIFO was full
clr_overflow  in  1  clears overflow
frame_cnt  out  16  completed-frame count, wraps

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0.
- Input capture: pclk, vsync, href and data each pass through a 2-flop synchronizer.
  - A sample event occurs on the cycle a rising edge of synchronized pclk is detected.
  - Data is taken from the same synchronizer stage, so it stays aligned with pclk.
- States:
  - IDLE -> WAIT_VS when enable=1.
  - WAIT_VS -> ACTIVE on a falling edge of synced vsync. At this transition, latch the crop fields and snapshot, and zero x and y.
  - ACTIVE -> WAIT_VS on a vsync rising edge when not in snapshot mode.
  - ACTIVE -> DONE on a vsync rising edge when in snapshot mode.
  - DONE -> IDLE when enable=0.
  - Any state -> IDLE when enable=0, except DONE, which waits for enable=0 as above. Dropping enable does not flush the FIFO.
  - A frame that starts while vsync is already low is ignored; a falling edge is required.
- Counters and frame end:
  - x increments on every sample event while href=1.
  - On an href falling edge, x clears and y increments; y saturates at all-ones.
  - Both x and y count only in ACTIVE.
  - On the vsync rising edge that leaves ACTIVE: frame_done pulses and frame_cnt increments, even if the frame was partial.
- Pixel acceptance: x0 <= x < x0+w and y0 <= y < y0+h, using CNT_W+1-bit compare sums.
- Packing:
  - Accepted pixels fill a PACK-slot shift register, first pixel at bits [PIX_W-1:0].
  - When PACK slots are full, the word is written to the FIFO on the next cycle.
  - out_sof is set on the first word at (x0,y0).
  - out_eol is set on the word whose last pixel has x = x0+w-1.
  - A partial pack (href ends early) is discarded at the href fall.
- FIFO:
  - A word transfers when out_valid && out_ready.
  - A simultaneous read and write when full succeeds.
  - A write when full and not reading drops the word and sets overflow.
  - clr_overflow has priority over a same-cycle set.
- Latency: a pixel's sync-edge sample reaches out_valid no later than 5 clk after the pclk edge that completes its word.

Optional Feature:
DCMI_CROP_EN:
- Defined: cropping as above.
- Undefined: the crop inputs are ignored; every href-active pixel is accepted; out_eol marks the last word before each href fall; out_sof marks the first word of the frame. Line width must then be a multiple of PACK.

Test Plan:
- PACK=2, 4 lines x 8 px, data = 16*y+x, crop 0/0/8/4, out_ready=1 -> 16 words. Word0 = {1,0} with sof. Words 3,7,11,15 carry eol. frame_done pulses once; frame_cnt=1.
- Crop x0=2, y0=1, w=4, h=2 on the same frame -> 4 words: {19,18} sof, {21,20} eol, {35,34}, {37,36} eol.
- snapshot=1, three frames sent -> one frame of words only. State stays DONE and busy=1 until enable=0, then busy=0.
- out_ready=0 for a full frame with FIFO_DEPTH=8 -> exactly 8 words retained, overflow=1. clr_overflow clears it; words 0-7 then drain in order.
- Reset asserted mid-line -> all outputs 0 and FIFO empty. After release with enable=1, capture resumes only at the next vsync fall.
- href shortened to 7 px on a line, crop off -> odd last pixel discarded; no extra word emitted.
